tse_reset_sequencer: RTL and testbench

- Host-side initiator for the MAC per-domain reset distribution. A one-cycle software reset request starts a sequenced reset.
- The block drives a level reset request into the reset distribution logic. It then waits until every clock domain reports it is in reset, holds reset for a programmable time, releases it, and waits until every domain reports it is out of reset.
- It reports busy, done and timeout status to the register block. Everything runs in the host (AHB) clock domain.

---
 rtl/tse_reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_tse_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tse_reset_sequencer.sv
// Host-clock reset sequencer: request, wait for all domain acks, hold, release, wait for acks to clear.
// Optional macro TSE_RST_SEQ_ACK_MASK_EN adds dom_ack_mask to exclude domains from the ack checks.
module tse_reset_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] dom_rst_ack,
`ifdef TSE_RST_SEQ_ACK_MASK_EN
  input  logic [NUM_DOMAINS-1:0] dom_ack_mask,
`endif
  output logic                   mac_rst_req,
  output logic                   rst_busy,
  output logic                   rst_done,
  output logic                   rst_timeout,
  output logic [NUM_DOMAINS-1:0] dom_ack_sync
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ASSERT,
    HOLD,
    WAIT_RELEASE,
    DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_nxt;
  logic                     mac_nxt;
  logic                     busy_nxt;
  logic                     done_nxt;
  logic                     to_nxt;
  logic [NUM_DOMAINS-1:0]   ack_meta_p0;
  logic [NUM_DOMAINS-1:0]   ack_sync_p1;
  logic [NUM_DOMAINS-1:0]   ack_hi_view;
  logic [NUM_DOMAINS-1:0]   ack_lo_view;
  logic                     all_hi;
  logic                     all_lo;

  // Stage p0/p1: two-flop synchronizer for the asynchronous domain acks
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      ack_meta_p0 <= '0;
      ack_sync_p1 <= '0;
    end else begin
      ack_meta_p0 <= dom_rst_ack;
      ack_sync_p1 <= ack_meta_p0;
    end
  end

  assign dom_ack_sync = ack_sync_p1;

`ifdef TSE_RST_SEQ_ACK_MASK_EN
  // A masked domain reads as "in reset" for entry and "out of reset" for exit.
  assign ack_hi_view = ack_sync_p1 | dom_ack_mask;
  assign ack_lo_view = ack_sync_p1 & ~dom_ack_mask;
`else
  assign ack_hi_view = ack_sync_p1;
  assign ack_lo_view = ack_sync_p1;
`endif

  assign all_hi = &ack_hi_view;
  assign all_lo = ~|ack_lo_view;

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    mac_nxt   = mac_rst_req;
    to_nxt    = rst_timeout;
    done_nxt  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sw_rst_req) begin
          state_nxt = WAIT_ASSERT;
          mac_nxt   = 1'b1;
          to_nxt    = 1'b0;
          cnt_nxt   = '0;
        end
      end
      WAIT_ASSERT: begin
        if (all_hi) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_nxt = IDLE;
          mac_nxt   = 1'b0;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_nxt = WAIT_RELEASE;
          mac_nxt   = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      WAIT_RELEASE: begin
        if (all_lo) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (cnt_q == TMO_LAST) begin
          state_nxt = IDLE;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        mac_nxt   = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Stage p1 -> outputs: all status is registered off the next-state decode
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mac_rst_req <= 1'b0;
      rst_busy    <= 1'b0;
      rst_done    <= 1'b0;
      rst_timeout <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      mac_rst_req <= mac_nxt;
      rst_busy    <= busy_nxt;
      rst_done    <= done_nxt;
      rst_timeout <= to_nxt;
    end
  end

endmodule

// File: tb/tb_tse_reset_sequencer.sv
// Bench for tse_reset_sequencer: domain-ack environment plus interval-based expectations per sequence.
module tb_tse_reset_sequencer;

  localparam int ND   = 4;
  localparam int HOLD = 16;
  localparam int TMO  = 1024;
  localparam int CW   = 11;

  logic          hclk        = 1'b0;
  logic          hresetn     = 1'b0;
  logic          sw_rst_req  = 1'b0;
  logic [ND-1:0] dom_rst_ack = '0;
  logic          mac_rst_req;
  logic          rst_busy;
  logic          rst_done;
  logic          rst_timeout;
  logic [ND-1:0] dom_ack_sync;
`ifdef TSE_RST_SEQ_ACK_MASK_EN
  logic [ND-1:0] dom_ack_mask = '0;
`endif

  tse_reset_sequencer #(
    .NUM_DOMAINS   (ND),
    .HOLD_CYCLES   (HOLD),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .sw_rst_req  (sw_rst_req),
    .dom_rst_ack (dom_rst_ack),
`ifdef TSE_RST_SEQ_ACK_MASK_EN
    .dom_ack_mask(dom_ack_mask),
`endif
    .mac_rst_req (mac_rst_req),
    .rst_busy    (rst_busy),
    .rst_done    (rst_done),
    .rst_timeout (rst_timeout),
    .dom_ack_sync(dom_ack_sync)
  );

  always #5 hclk = ~hclk;

  int vectors     = 0;
  int miscompares = 0;

  // Environment: each domain echoes mac_rst_req after dly cycles, or is stuck low, or latches high.
  int            dly  [ND];
  int            mode [ND];
  logic [ND-1:0] latch_hi = '0;
  logic [15:0]   mac_sh   = '0;
  logic [ND-1:0] ack_h1   = '0;
  logic [ND-1:0] ack_h2   = '0;
  logic          hr_h1    = 1'b0;
  logic          hr_h2    = 1'b0;
  logic          to_flag  = 1'b0;
  logic [ND-1:0] mask_v   = '0;
  int            k0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [ND-1:0] obs, input logic [ND-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
    ack_h2 = ack_h1;
    ack_h1 = dom_rst_ack;
    hr_h2  = hr_h1;
    hr_h1  = hresetn;
    mac_sh = {mac_sh[14:0], mac_rst_req};
  endtask

  task automatic drive_ack();
    logic [ND-1:0] a;
    a = '0;
    for (int i = 0; i < ND; i++) begin
      case (mode[i])
        1: a[i] = 1'b0;
        2: begin
          latch_hi[i] = latch_hi[i] | mac_sh[dly[i]];
          a[i] = latch_hi[i];
        end
        default: a[i] = mac_sh[dly[i]];
      endcase
    end
    dom_rst_ack = a;
  endtask

  // Synchronized acks are the acks driven two cycles ago, zero if reset was seen in that window.
  task automatic check_outs(input string tag, input logic em, input logic eb,
                            input logic ed, input logic et);
    logic [ND-1:0] es;
    es = (!hr_h1 || !hr_h2) ? '0 : ack_h2;
    chk1({tag, ".mac_rst_req"}, mac_rst_req, em);
    chk1({tag, ".rst_busy"},    rst_busy,    eb);
    chk1({tag, ".rst_done"},    rst_done,    ed);
    chk1({tag, ".rst_timeout"}, rst_timeout, et);
    chkv({tag, ".dom_ack_sync"}, dom_ack_sync, es);
  endtask

  task automatic idle(input string tag, input int n);
    for (int c = 0; c < n; c++) begin
      check_outs(tag, 1'b0, 1'b0, 1'b0, to_flag);
      sw_rst_req = 1'b0;
      hresetn    = 1'b1;
      drive_ack();
      tick();
    end
  endtask

  // kind 0: completes; 1: assert-side timeout; 2: release-side timeout.
  // rst_off >= 0 pulses hresetn low that many cycles into HOLD.
  task automatic run_seq(input string tag, input int kind, input int rst_off);
    int   md;
    int   hold_at;
    int   fall_at;
    int   done_at;
    int   busy_end;
    int   to_at;
    int   rst_at;
    int   ncyc;
    logic prior_to;
    logic gone;
    logic em;
    logic eb;
    logic ed;
    logic et;
    md = 0;
    for (int i = 0; i < ND; i++)
      if (mode[i] != 1 && !mask_v[i] && dly[i] > md) md = dly[i];
    hold_at = 4 + md;
    fall_at = hold_at + HOLD;
    done_at = fall_at + md + 3;
    case (kind)
      1: begin
        busy_end = TMO;
        fall_at  = TMO + 1;
        to_at    = TMO + 1;
      end
      2: begin
        busy_end = fall_at + TMO - 1;
        to_at    = fall_at + TMO;
      end
      default: begin
        busy_end = done_at;
        to_at    = -1;
      end
    endcase
    rst_at   = (rst_off >= 0) ? hold_at + rst_off : -1;
    ncyc     = busy_end + 6;
    prior_to = to_flag;
    for (int c = 0; c <= ncyc; c++) begin
      gone = (rst_at >= 0) && (c > rst_at);
      em = !gone && (c >= 1) && (c < fall_at);
      eb = !gone && (c >= 1) && (c <= busy_end);
      ed = !gone && (kind == 0) && (c == done_at);
      et = !gone && ((c == 0) ? prior_to : ((to_at >= 0) && (c >= to_at)));
      check_outs(tag, em, eb, ed, et);
      sw_rst_req = (c == 0);
      if (c >= 1 && c <= busy_end && (rst_at < 0 || c < rst_at)) begin
        if ($urandom_range(0, 7) == 0) sw_rst_req = 1'b1;
        if (c == busy_end || c == hold_at + 3) sw_rst_req = 1'b1;
      end
      hresetn = (c != rst_at);
      drive_ack();
      tick();
    end
    sw_rst_req = 1'b0;
    to_flag    = (kind != 0) && (rst_at < 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < ND; i++) begin
      dly[i]  = 3;
      mode[i] = 0;
    end
    hresetn = 1'b0;
    repeat (3) begin
      drive_ack();
      tick();
    end
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    hresetn = 1'b1;
    drive_ack();
    tick();
    idle("idle", 4);

    run_seq("nominal", 0, -1);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ND; i++) dly[i] = $urandom_range(0, 4);
      run_seq("rand_nominal", 0, -1);
    end

    for (int i = 0; i < ND; i++) dly[i] = 3;
    k0 = $urandom_range(0, ND - 1);
    mode[k0] = 1;
    run_seq("assert_timeout", 1, -1);
    mode[k0] = 0;
    idle("timeout_sticky", 8);
    run_seq("after_timeout", 0, -1);

    mode[k0] = 2;
    run_seq("release_timeout", 2, -1);
    mode[k0] = 0;
    latch_hi = '0;
    idle("release_sticky", 8);

    run_seq("mid_reset", 0, $urandom_range(0, HOLD - 1));
    idle("post_reset_idle", 12);
    run_seq("post_reset_seq", 0, -1);

`ifdef TSE_RST_SEQ_ACK_MASK_EN
    mask_v         = '0;
    mask_v[ND-1]   = 1'b1;
    dom_ack_mask   = mask_v;
    mode[ND-1]     = 1;
    run_seq("mask", 0, -1);
    mode[ND-1]     = 0;
    mask_v         = '0;
    dom_ack_mask   = '0;
    idle("mask_idle", 6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
